// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared decoder defaults, loader state type and the LLR saturation helper
// used by the ldpc_llr_loader slice.
package ldpc_pkg;

  localparam int LDPC_DATA_W = 8;
  localparam int LDPC_R      = 24;
  localparam int LDPC_D      = 24;
  localparam int LDPC_LANES  = 4;
  localparam int LLR_MAX     = (1 << (LDPC_DATA_W - 1)) - 1;
  localparam int BEAT_CNT_W  = $clog2(LDPC_R * LDPC_D / LDPC_LANES);

  typedef enum logic {
    ST_LOAD,
    ST_DROP
  } load_state_e;

  // Symmetric clamp to +/-(2^(w-1)-1) so the most negative code never reaches the core.
  function automatic int sat_llr(input int s, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/llr_sat.sv
// llr_sat: combinational saturation of one raw channel sample into a decoder LLR,
// flagging whether the sample had to be clamped.
module llr_sat
  import ldpc_pkg::*;
#(
  parameter int in_w   = 12,
  parameter int data_w = LDPC_DATA_W
) (
  input  logic [in_w-1:0]   s_i,
  output logic [data_w-1:0] llr_o,
  output logic              sat_o
);

  int s_val;
  int c_val;

  always_comb begin
    s_val = int'($signed(s_i));
    c_val = sat_llr(s_val, data_w);
    llr_o = data_w'(c_val);
    sat_o = (c_val != s_val);
  end

endmodule

// File: rtl/ldpc_llr_loader.sv
// ldpc_llr_loader: saturates LLR beats and assembles whole frames into a ping-pong buffer
// presented on sig. Define LDPC_LLR_SAT_CNT_EN to build the per-buffer saturation counters.
module ldpc_llr_loader
  import ldpc_pkg::*;
#(
  parameter int data_w = LDPC_DATA_W,
  parameter int R      = LDPC_R,
  parameter int D      = LDPC_D,
  parameter int in_w   = 12,
  parameter int LANES  = LDPC_LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*in_w-1:0]   in_data,
  input  logic                    in_last,
  output logic [R*D*data_w-1:0]   sig,
  output logic                    frame_valid,
  input  logic                    frame_ack,
  output logic                    frame_err,
  output logic [9:0]              sat_count
);

  localparam int N      = R * D;
  localparam int B      = N / LANES;
  localparam int CNT_W  = $clog2(B);
  localparam int BEAT_W = LANES * data_w;

  load_state_e          state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic                 err_q, err_d;
  logic [N*data_w-1:0]  buf_q [2];

  logic                 accept;
  logic                 last_beat;
  logic                 ack;
  logic                 store;
  logic                 drop_frame;
  logic [BEAT_W-1:0]    sat_data;
  logic [LANES-1:0]     sat_flags;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    llr_sat #(.in_w(in_w), .data_w(data_w)) u_sat (
      .s_i   (in_data[l*in_w +: in_w]),
      .llr_o (sat_data[l*data_w +: data_w]),
      .sat_o (sat_flags[l])
    );
  end

  assign in_ready    = !full_q[wr_sel_q];
  assign frame_valid = full_q[rd_sel_q];
  assign sig         = buf_q[rd_sel_q];
  assign frame_err   = err_q;

  // A misframed beat (short or long) discards the partial frame; a long frame also
  // swallows everything up to its own in_last before filling restarts.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    err_d      = 1'b0;
    store      = 1'b0;
    drop_frame = 1'b0;
    accept     = in_valid && in_ready;
    last_beat  = (beat_cnt_q == CNT_W'(B - 1));
    ack        = frame_ack && full_q[rd_sel_q];

    if (accept) begin
      case (state_q)
        ST_LOAD: begin
          store = 1'b1;
          if (in_last && last_beat) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
            beat_cnt_d       = '0;
          end else if (in_last || last_beat) begin
            drop_frame = 1'b1;
            err_d      = 1'b1;
            beat_cnt_d = '0;
            if (!in_last) state_d = ST_DROP;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        ST_DROP: begin
          if (in_last) state_d = ST_LOAD;
        end
        default: state_d = ST_LOAD;
      endcase
    end

    if (ack) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      beat_cnt_q <= '0;
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      err_q      <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      err_q      <= err_d;
      if (store) buf_q[wr_sel_q][int'(beat_cnt_q)*BEAT_W +: BEAT_W] <= sat_data;
    end
  end

`ifdef LDPC_LLR_SAT_CNT_EN
  logic [9:0] sat_cnt_q [2];
  logic [9:0] lane_sats;

  always_comb begin
    lane_sats = '0;
    for (int l = 0; l < LANES; l++) lane_sats = lane_sats + 10'(sat_flags[l]);
  end

  // The first beat of a frame restarts its buffer's count; a drop zeroes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt_q[0] <= '0;
      sat_cnt_q[1] <= '0;
    end else begin
      if (store) begin
        if (beat_cnt_q == '0) sat_cnt_q[wr_sel_q] <= lane_sats;
        else                  sat_cnt_q[wr_sel_q] <= sat_cnt_q[wr_sel_q] + lane_sats;
      end
      if (drop_frame) sat_cnt_q[wr_sel_q] <= '0;
    end
  end

  assign sat_count = sat_cnt_q[rd_sel_q];
`else
  logic unused_sat;
  assign unused_sat = ^{sat_flags, drop_frame};
  assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// tb_ldpc_llr_loader: directed self-checking bench for ldpc_llr_loader covering framing,
// saturation, ping-pong back-pressure, misframed drops and mid-frame reset.
module tb_ldpc_llr_loader;
  import ldpc_pkg::*;

  localparam int DW   = 8;
  localparam int IW   = 12;
  localparam int LN   = 4;
  localparam int NLLR = 576;
  localparam int NB   = 144;
`ifdef LDPC_LLR_SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LN*IW-1:0]    in_data = '0;
  logic                in_last = 1'b0;
  logic [NLLR*DW-1:0]  sig;
  logic                frame_valid;
  logic                frame_ack = 1'b0;
  logic                frame_err;
  logic [9:0]          sat_count;

  int vectors = 0;
  int miscompares = 0;

  ldpc_llr_loader #(.data_w(DW), .R(24), .D(24), .in_w(IW), .LANES(LN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .sig         (sig),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_err   (frame_err),
    .sat_count   (sat_count)
  );

  always #5 clk = ~clk;

  // Mode 0 is the plain ramp, mode 99 the saturation corner beat, others distinct in-range patterns.
  function automatic int sampleVal(input int mode, input int i);
    if (mode == 0) return i;
    if (mode == 99) begin
      case (i)
        0: return 2047;
        1: return -2048;
        2: return -127;
        3: return -128;
        default: return 0;
      endcase
    end
    return ((i + 37 * mode) % 255) - 127;
  endfunction

  function automatic int expLlr(input int v);
    if (v > LLR_MAX) return LLR_MAX;
    if (v < -LLR_MAX) return -LLR_MAX;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int mode, input int beat, input logic last);
    for (int l = 0; l < LN; l++) in_data[l*IW +: IW] = IW'(sampleVal(mode, beat * LN + l));
    in_valid = 1'b1;
    in_last  = last;
    if (!in_ready) checkOutput("in_ready_before_beat", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sendBeats(input int mode, input int first, input int count, input int lastAt);
    for (int b = first; b < first + count; b++) applyStimulus(mode, b, b == lastAt);
  endtask

  task automatic checkFrame(input string tag, input int mode);
    int firstBad;
    logic [DW-1:0] e;
    firstBad = -1;
    for (int i = 0; i < NLLR; i++) begin
      e = DW'(expLlr(sampleVal(mode, i)));
      if (sig[i*DW +: DW] !== e && firstBad < 0) firstBad = i;
    end
    checkOutput(tag, 32'(firstBad), 32'hFFFF_FFFF);
  endtask

  task automatic pulseAck();
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_in_ready"}, 32'(in_ready), 1);
    checkOutput({pfx, "_frame_valid"}, 32'(frame_valid), 0);
    checkOutput({pfx, "_frame_err"}, 32'(frame_err), 0);
    checkOutput({pfx, "_sat_count"}, 32'(sat_count), 0);
    checkOutput({pfx, "_sig_zero"}, 32'(|sig), 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b1;
    stepCycle();

    // Ramp frame: LLRs 128..575 clamp to +127.
    sendBeats(0, 0, NB, NB - 1);
    checkOutput("ramp_valid", 32'(frame_valid), 1);
    checkFrame("ramp_content", 0);
    checkOutput("ramp_sat_count", 32'(sat_count), SAT_EN ? 448 : 0);
    checkOutput("ramp_in_ready", 32'(in_ready), 1);
    checkOutput("ramp_no_err", 32'(frame_err), 0);
    pulseAck();
    checkOutput("ramp_acked_valid", 32'(frame_valid), 0);

    // Corner lanes +2047, -2048, -127, -128.
    sendBeats(99, 0, NB, NB - 1);
    checkOutput("sat_valid", 32'(frame_valid), 1);
    checkOutput("sat_llr0", 32'(sig[0 +: DW]), 32'h7F);
    checkOutput("sat_llr1", 32'(sig[DW +: DW]), 32'h81);
    checkOutput("sat_llr2", 32'(sig[2*DW +: DW]), 32'h81);
    checkOutput("sat_llr3", 32'(sig[3*DW +: DW]), 32'h81);
    checkFrame("sat_content", 99);
    checkOutput("sat_count_corner", 32'(sat_count), SAT_EN ? 3 : 0);
    pulseAck();

    // Two frames fill both buffers and stall the input.
    sendBeats(1, 0, NB, NB - 1);
    checkOutput("pp_f1_valid", 32'(frame_valid), 1);
    checkOutput("pp_f1_ready", 32'(in_ready), 1);
    sendBeats(2, 0, NB, NB - 1);
    checkOutput("pp_full_ready", 32'(in_ready), 0);
    checkOutput("pp_full_valid", 32'(frame_valid), 1);
    checkFrame("pp_f1_content", 1);
    checkOutput("pp_f1_sat_count", 32'(sat_count), 0);
    pulseAck();
    checkOutput("pp_f2_valid", 32'(frame_valid), 1);
    checkOutput("pp_f2_ready", 32'(in_ready), 1);
    checkFrame("pp_f2_content", 2);
    sendBeats(3, 0, NB, NB - 1);
    checkFrame("pp_f2_stable", 2);
    pulseAck();
    checkOutput("pp_f3_valid", 32'(frame_valid), 1);
    checkFrame("pp_f3_content", 3);
    pulseAck();
    checkOutput("pp_empty_valid", 32'(frame_valid), 0);

    // A stray ack with nothing presented must not move the read side.
    pulseAck();

    // Short frame: in_last on beat 50.
    sendBeats(4, 0, 51, 50);
    checkOutput("short_err_pulse", 32'(frame_err), 1);
    checkOutput("short_valid", 32'(frame_valid), 0);
    stepCycle();
    checkOutput("short_err_clear", 32'(frame_err), 0);
    sendBeats(5, 0, NB, NB - 1);
    checkOutput("after_short_valid", 32'(frame_valid), 1);
    checkFrame("after_short_content", 5);
    pulseAck();

    // Long frame: 150 beats, last on 149.
    sendBeats(6, 0, NB, -1);
    checkOutput("long_err_pulse", 32'(frame_err), 1);
    checkOutput("long_valid", 32'(frame_valid), 0);
    sendBeats(6, NB, 6, 149);
    checkOutput("long_tail_err", 32'(frame_err), 0);
    checkOutput("long_tail_valid", 32'(frame_valid), 0);
    sendBeats(7, 0, NB, NB - 1);
    checkOutput("after_long_valid", 32'(frame_valid), 1);
    checkOutput("after_long_err", 32'(frame_err), 0);
    checkFrame("after_long_content", 7);
    pulseAck();

    // Reset mid-frame while the other buffer is presented.
    sendBeats(8, 0, NB, NB - 1);
    checkOutput("pre_rst_valid", 32'(frame_valid), 1);
    sendBeats(9, 0, 70, -1);
    rst = 1'b0;
    #1;
    checkResetOutputs("midrst");
    stepCycle();
    rst = 1'b1;
    stepCycle();
    sendBeats(10, 0, NB, NB - 1);
    checkOutput("post_rst_valid", 32'(frame_valid), 1);
    checkFrame("post_rst_content", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
